// File: rtl/race_timer.sv
// race_timer: race clock stage fed by the 1 Hz divider output.
// Synchronises the tick, runs the pre-race countdown, counts elapsed time
// as binary seconds plus BCD mm:ss, and freezes on finish, timeout or abort.
// Optional best-lap tracking is compiled in with `define RACE_TIMER_LAP_EN.
module race_timer #(
    parameter int COUNTDOWN_SEC  = 3,
    parameter int TIME_LIMIT_SEC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        start,
    input  logic        finish,
    input  logic        abort,
`ifdef RACE_TIMER_LAP_EN
    input  logic        lap,
`endif
    output logic [1:0]  state,
    output logic [1:0]  countdown,
    output logic        go,
    output logic        timeout,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [12:0] elapsed
`ifdef RACE_TIMER_LAP_EN
    ,
    output logic [12:0] best_lap,
    output logic        lap_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CDOWN = 2'd1,
        S_RACE  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [1:0]  CD_INIT = 2'(COUNTDOWN_SEC);
    localparam logic [12:0] LIMIT   = 13'(TIME_LIMIT_SEC);
    localparam logic [12:0] MAX_SEC = 13'd5999;

    // One-second increment of packed BCD {min_tens, min_ones, sec_tens, sec_ones}
    function automatic logic [15:0] bcd_inc(input logic [15:0] b);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = b;
        if (so == 4'd9) begin
            so = 4'd0;
            if (st == 4'd5) begin
                st = 4'd0;
                if (mo == 4'd9) begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    logic        s1, s2, s3;
    logic        tick_evt;
    state_t      state_q, state_d;
    logic [1:0]  cd_q, cd_d;
    logic        go_q, go_d;
    logic        to_q, to_d;
    logic [15:0] bcd_q, bcd_d;
    logic [12:0] el_q, el_d;
    logic        do_start;

    // Two-flop synchroniser plus edge register for the asynchronous tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_1hz;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_evt = s2 & ~s3;

    // State and time registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cd_q    <= 2'd0;
            go_q    <= 1'b0;
            to_q    <= 1'b0;
            bcd_q   <= 16'd0;
            el_q    <= 13'd0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            go_q    <= go_d;
            to_q    <= to_d;
            bcd_q   <= bcd_d;
            el_q    <= el_d;
        end
    end

    // Next state: abort beats finish beats tick beats start
    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        go_d     = 1'b0;
        to_d     = to_q;
        bcd_d    = bcd_q;
        el_d     = el_q;
        do_start = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cd_d    = 2'd0;
            to_d    = 1'b0;
            bcd_d   = 16'd0;
            el_d    = 13'd0;
        end else begin
            case (state_q)
                S_IDLE: do_start = start;
                S_CDOWN: begin
                    if (tick_evt) begin
                        if (cd_q == 2'd1) begin
                            cd_d    = 2'd0;
                            state_d = S_RACE;
                            go_d    = 1'b1;
                        end else if (cd_q != 2'd0) begin
                            cd_d = cd_q - 2'd1;
                        end
                    end
                end
                S_RACE: begin
                    if (finish) begin
                        // A tick landing with finish is deliberately dropped
                        state_d = S_FIN;
                        to_d    = 1'b0;
                    end else if (tick_evt && el_q != MAX_SEC) begin
                        el_d  = el_q + 13'd1;
                        bcd_d = bcd_inc(bcd_q);
                        if (LIMIT != 13'd0 && (el_q + 13'd1) == LIMIT) begin
                            state_d = S_FIN;
                            to_d    = 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    if (start) begin
                        bcd_d    = 16'd0;
                        el_d     = 13'd0;
                        to_d     = 1'b0;
                        do_start = 1'b1;
                    end
                end
                default: ;
            endcase
            if (do_start) begin
                if (CD_INIT != 2'd0) begin
                    state_d = S_CDOWN;
                    cd_d    = CD_INIT;
                end else begin
                    state_d = S_RACE;
                    go_d    = 1'b1;
                end
            end
        end
    end

`ifdef RACE_TIMER_LAP_EN
    logic [12:0] lap_start_q, lap_start_d;
    logic [12:0] best_q, best_d;
    logic        lv_q, lv_d;
    logic [12:0] lap_time;

    // Lap registers; best lap survives abort and is cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_start_q <= 13'd0;
            best_q      <= 13'h1FFF;
            lv_q        <= 1'b0;
        end else begin
            lap_start_q <= lap_start_d;
            best_q      <= best_d;
            lv_q        <= lv_d;
        end
    end

    // Lap timing: a lap or finish closes the current lap; zero-length laps are ignored
    always_comb begin
        lap_start_d = lap_start_q;
        best_d      = best_q;
        lv_d        = lv_q;
        lap_time    = el_q - lap_start_q;
        if (go_d) begin
            lap_start_d = 13'd0;
        end else if (!abort && state_q == S_RACE && (lap || finish) && lap_time != 13'd0) begin
            if (lap_time < best_q) begin
                best_d = lap_time;
                lv_d   = 1'b1;
            end
            lap_start_d = el_q;
        end
    end
`endif

    // Output mapping from registered state
    always_comb begin
        state     = state_q;
        countdown = cd_q;
        go        = go_q;
        timeout   = to_q;
        {min_tens, min_ones, sec_tens, sec_ones} = bcd_q;
        elapsed   = el_q;
`ifdef RACE_TIMER_LAP_EN
        best_lap  = best_q;
        lap_valid = lv_q;
`endif
    end

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer: directed bench for race_timer with a queue-based scoreboard.
// u_dut uses the default parameters; u_dut2 runs with no countdown and a 10 s limit.
module tb_race_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, tick_1hz, start, finish, abort, lap;
    logic start2, finish2, abort2;

    logic [1:0]  state1, cd1, state2, cd2;
    logic        go1, to1, go2, to2;
    logic [3:0]  mt1, mo1, st1, so1, mt2, mo2, st2, so2;
    logic [12:0] el1, el2;
    logic [12:0] best1, best2;
    logic        lv1, lv2;

    race_timer #(.COUNTDOWN_SEC(3), .TIME_LIMIT_SEC(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .start(start), .finish(finish), .abort(abort),
`ifdef RACE_TIMER_LAP_EN
        .lap(lap),
`endif
        .state(state1), .countdown(cd1), .go(go1), .timeout(to1),
        .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
        .elapsed(el1)
`ifdef RACE_TIMER_LAP_EN
        , .best_lap(best1), .lap_valid(lv1)
`endif
    );

    race_timer #(.COUNTDOWN_SEC(0), .TIME_LIMIT_SEC(10)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .start(start2), .finish(finish2), .abort(abort2),
`ifdef RACE_TIMER_LAP_EN
        .lap(1'b0),
`endif
        .state(state2), .countdown(cd2), .go(go2), .timeout(to2),
        .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
        .elapsed(el2)
`ifdef RACE_TIMER_LAP_EN
        , .best_lap(best2), .lap_valid(lv2)
`endif
    );

`ifndef RACE_TIMER_LAP_EN
    assign best1 = 13'h0;
    assign lv1   = 1'b0;
    assign best2 = 13'h0;
    assign lv2   = 1'b0;
`endif

    logic [34:0] obs1, obs2, obs_lap;
    assign obs1    = {state1, cd1, go1, to1, mt1, mo1, st1, so1, el1};
    assign obs2    = {state2, cd2, go2, to2, mt2, mo2, st2, so2, el2};
    assign obs_lap = {21'd0, lv1, best1};

    typedef struct {
        string       tag;
        int          sel;
        logic [34:0] exp;
    } ent_t;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Expected snapshot built from seconds by division, independent of carry logic
    function automatic logic [34:0] mk(int st, int cd, int g, int t, int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {2'(st), 2'(cd), 1'(g), 1'(t), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 13'(secs)};
    endfunction

    function automatic logic [34:0] mk_lap(int valid, int best);
        return {21'd0, 1'(valid), 13'(best)};
    endfunction

    task automatic expect_push(input string tag, input int sel, input logic [34:0] e);
        ent_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic check_pop();
        ent_t        e;
        logic [34:0] o;
        n_chk++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=0 expected=1 entries");
        end else begin
            e = q.pop_front();
            case (e.sel)
                0:       o = obs1;
                1:       o = obs2;
                default: o = obs_lap;
            endcase
            assert (o === e.exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_rise();
        tick_1hz = 1'b1;
        cyc(3);
    endtask

    task automatic tick_fall();
        tick_1hz = 1'b0;
        cyc(3);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_rise();
            tick_fall();
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; start = 1'b0; finish = 1'b0; abort = 1'b0; lap = 1'b0;
        start2 = 1'b0; finish2 = 1'b0; abort2 = 1'b0;

        // Reset with ticks toggling
        cyc(1);
        tick_1hz = 1'b1;
        expect_push("reset_hold", 0, mk(0, 0, 0, 0, 0));
        cyc(2);
        check_pop();
        tick_1hz = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        expect_push("reset_release", 0, mk(0, 0, 0, 0, 0));
        expect_push("reset_dut2", 1, mk(0, 0, 0, 0, 0));
`ifdef RACE_TIMER_LAP_EN
        expect_push("reset_best_lap", 2, mk_lap(0, 13'h1FFF));
`endif
        cyc(1);
        check_pop();
        check_pop();
`ifdef RACE_TIMER_LAP_EN
        check_pop();
`endif
        expect_push("idle_ignores_tick", 0, mk(0, 0, 0, 0, 0));
        ticks(1);
        check_pop();

        // No-countdown instance: immediate go, then time limit
        start2 = 1'b1;
        expect_push("dut2_go", 1, mk(2, 0, 1, 0, 0));
        cyc(1);
        start2 = 1'b0;
        check_pop();
        expect_push("dut2_go_drop", 1, mk(2, 0, 0, 0, 0));
        cyc(1);
        check_pop();
        expect_push("dut2_9s", 1, mk(2, 0, 0, 0, 9));
        ticks(9);
        check_pop();
        expect_push("dut2_limit", 1, mk(3, 0, 0, 1, 10));
        ticks(1);
        check_pop();
        expect_push("dut2_frozen", 1, mk(3, 0, 0, 1, 10));
        ticks(2);
        check_pop();

        // Countdown 3, 2, 1, go
        start = 1'b1;
        expect_push("cd_3", 0, mk(1, 3, 0, 0, 0));
        cyc(1);
        start = 1'b0;
        check_pop();
        start = 1'b1;
        expect_push("cd_start_ignored", 0, mk(1, 3, 0, 0, 0));
        cyc(1);
        start = 1'b0;
        check_pop();
        expect_push("cd_2", 0, mk(1, 2, 0, 0, 0));
        tick_rise();
        check_pop();
        tick_fall();
        expect_push("cd_1", 0, mk(1, 1, 0, 0, 0));
        tick_rise();
        check_pop();
        tick_fall();
        expect_push("go_pulse", 0, mk(2, 0, 1, 0, 0));
        tick_rise();
        check_pop();
        expect_push("go_single", 0, mk(2, 0, 0, 0, 0));
        cyc(1);
        check_pop();
        tick_fall();

        // Counting with BCD carries, then finish freezes
        expect_push("count_10", 0, mk(2, 0, 0, 0, 10));
        ticks(10);
        check_pop();
        expect_push("count_60", 0, mk(2, 0, 0, 0, 60));
        ticks(50);
        check_pop();
        expect_push("count_75", 0, mk(2, 0, 0, 0, 75));
        ticks(15);
        check_pop();
        finish = 1'b1;
        expect_push("finish", 0, mk(3, 0, 0, 0, 75));
        cyc(1);
        finish = 1'b0;
        check_pop();
        expect_push("finish_frozen", 0, mk(3, 0, 0, 0, 75));
        ticks(5);
        check_pop();

        // Restart from FINISHED, then finish coinciding with a tick
        start = 1'b1;
        expect_push("restart", 0, mk(1, 3, 0, 0, 0));
        cyc(1);
        start = 1'b0;
        check_pop();
        ticks(3);
        expect_push("count_5", 0, mk(2, 0, 0, 0, 5));
        ticks(5);
        check_pop();
        tick_1hz = 1'b1;
        cyc(2);
        finish = 1'b1;
        expect_push("finish_with_tick", 0, mk(3, 0, 0, 0, 5));
        cyc(1);
        finish = 1'b0;
        check_pop();
        tick_fall();
        expect_push("finish_tick_frozen", 0, mk(3, 0, 0, 0, 5));
        ticks(1);
        check_pop();

        // Abort mid-race, and abort beating start
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        ticks(3);
        expect_push("count_30", 0, mk(2, 0, 0, 0, 30));
        ticks(30);
        check_pop();
        abort = 1'b1;
        expect_push("abort", 0, mk(0, 0, 0, 0, 0));
        cyc(1);
        abort = 1'b0;
        check_pop();
        start = 1'b1;
        abort = 1'b1;
        expect_push("abort_beats_start", 0, mk(0, 0, 0, 0, 0));
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        check_pop();

`ifdef RACE_TIMER_LAP_EN
        // Laps at 20 s and 45 s, finish at 65 s
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        ticks(3);
        ticks(20);
        lap = 1'b1;
        expect_push("lap_first", 2, mk_lap(1, 20));
        cyc(1);
        lap = 1'b0;
        check_pop();
        ticks(25);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        ticks(20);
        finish = 1'b1;
        expect_push("lap_finish_state", 0, mk(3, 0, 0, 0, 65));
        expect_push("lap_best", 2, mk_lap(1, 20));
        cyc(1);
        finish = 1'b0;
        check_pop();
        check_pop();
        abort = 1'b1;
        expect_push("lap_kept_after_abort", 2, mk_lap(1, 20));
        cyc(1);
        abort = 1'b0;
        check_pop();
`endif

        // Saturation at 99:59
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        ticks(3);
        expect_push("count_600", 0, mk(2, 0, 0, 0, 600));
        ticks(600);
        check_pop();
        expect_push("count_5998", 0, mk(2, 0, 0, 0, 5998));
        ticks(5398);
        check_pop();
        expect_push("saturate_9959", 0, mk(2, 0, 0, 0, 5999));
        ticks(3);
        check_pop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/race_timer.md
# race_timer

Race timing stage that consumes the 1 Hz square wave from the clock divider and runs the race clock. It drives a start countdown, counts elapsed race time as BCD mm:ss for the seven-segment display driver, and freezes the time on finish, timeout or abort. It sits between the divider and the display/game-control logic, in the system clock domain.

## Interface
Parameters:
- COUNTDOWN_SEC, 3: pre-race countdown length in seconds; legal values are 0..3.
- TIME_LIMIT_SEC, 0: race time limit in seconds; legal values are 0..5999; 0 means no limit.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset; synchronous, active-low.
- tick_1hz  in  1  1 Hz square wave from the divider, asynchronous to clk; each rising edge marks one second.
- start  in  1  one-cycle pulse from the debounced start button.
- finish  in  1  one-cycle pulse when the car crosses the line.
- abort  in  1  one-cycle pulse that cancels the race.
- lap  in  1  one-cycle lap-line pulse; present only with RACE_TIMER_LAP_EN.
- state  out  2  0 = IDLE, 1 = COUNTDOWN, 2 = RACING, 3 = FINISHED.
- countdown  out  2  seconds remaining before go.
- go  out  1  one-cycle pulse, high in the first RACING cycle.
- timeout  out  1  high while in FINISHED when the time limit ended the race.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  elapsed time as BCD digits.
- elapsed  out  13  elapsed time as binary seconds.
- best_lap  out  13  best lap time in binary seconds; present only with RACE_TIMER_LAP_EN.
- lap_valid  out  1  high once best_lap holds a lap; present only with RACE_TIMER_LAP_EN.

## Operation
- Reset values (rst_n low at a clk edge): every output is 0, state is IDLE, best_lap is 13'h1FFF, and the tick synchroniser registers are 0.
- Tick path:
  - tick_1hz passes through 2 flops (s1, s2) and an edge register (s3).
  - tick_evt = s2 & ~s3.
  - There is exactly one tick_evt per tick_1hz rising edge.
- Event priority within one cycle: rst_n, then abort, then finish, then tick_evt, then start.
- IDLE:
  - start with COUNTDOWN_SEC>0: go to COUNTDOWN, countdown=COUNTDOWN_SEC.
  - start with COUNTDOWN_SEC=0: go straight to RACING and pulse go.
- COUNTDOWN:
  - Each tick_evt decrements countdown.
  - A tick_evt with countdown==1 sets countdown=0, enters RACING and pulses go.
  - start is ignored.
- RACING:
  - Each tick_evt adds 1 to elapsed and to the BCD digits.
  - sec_ones wraps 9→0 with carry into sec_tens; sec_tens wraps 5→0 with carry into min_ones; min_ones wraps 9→0 with carry into min_tens.
  - At 99:59 (elapsed 5999) the count saturates: no wrap, state unchanged.
  - If TIME_LIMIT_SEC≠0 and the increment makes elapsed==TIME_LIMIT_SEC: go to FINISHED with timeout=1.
  - finish: go to FINISHED with timeout=0; a tick_evt in the same cycle is dropped.
- FINISHED:
  - Time is frozen and tick_evt is ignored.
  - start clears the time and timeout, then takes the same start path as IDLE.
- abort in any state: next cycle is IDLE with the time, countdown and timeout cleared. best_lap is kept.
- start and abort in the same cycle: abort wins.

## Timing
- A tick_1hz rising edge first sampled at clk edge N updates the counters at edge N+2. Input-to-digit latency is 2–3 clk cycles.
- State, go and timeout are registered. go is high for exactly 1 cycle, the cycle in which state first reads 2.
- start, finish and abort act at the first clk edge where they are high. The resulting state is visible the following cycle.
- The BCD digits and elapsed update on the same edge and are always consistent.
- Outputs are stable for at least 50e6−3 cycles between tick updates.

## Configuration
- RACE_TIMER_LAP_EN defined:
  - The lap, best_lap and lap_valid ports exist.
  - An internal 13-bit lap_start register is reset to 0 on entry to RACING.
  - In RACING, a lap or finish pulse computes lap_time = elapsed − lap_start. If lap_time < best_lap: best_lap=lap_time, lap_valid=1. Then lap_start=elapsed.
  - A lap with lap_time==0 is ignored.
  - lap outside RACING is ignored.
  - best_lap and lap_valid are cleared only by reset.
- RACE_TIMER_LAP_EN undefined: those ports and the lap_start and best_lap registers are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n low 2 cycles, drive ticks -> all outputs 0, state=0, digits 00:00, tick ignored.
- Countdown: start then 3 ticks -> countdown reads 3, 2, 1, then state=2 with a single-cycle go pulse and countdown=0.
- Counting and finish: 75 ticks in RACING -> min_tens=0, min_ones=1, sec_tens=1, sec_ones=5, elapsed=75. finish then 5 more ticks -> state=3, still 01:15.
- Limit and simultaneous events:
  - TIME_LIMIT_SEC=10 -> after the 10th tick state=3, timeout=1, 00:10.
  - Separately, finish in the same cycle as a tick_evt at 00:05 -> frozen at 00:05.
- Abort and saturation:
  - abort at 00:30 -> IDLE, zeros the next cycle.
  - Force elapsed=5998 with TIME_LIMIT_SEC=0, then 3 ticks -> 99:59 held, state=2.
- Laps (macro on): lap at 20 s, 45 s, finish at 65 s -> best_lap=20, lap_valid=1. A following abort keeps best_lap=20.
